// File: rtl/keymgr_pkg.sv
// Shared key manager definitions for the sideload clear/wipe sequencer:
// share geometry, sequencer states, PRNG seed constant and LFSR step.
package keymgr_pkg;

  localparam int unsigned Shares       = 2;
  localparam int unsigned RandWidth    = 32;
  localparam int unsigned EdnWidth     = 32;
  localparam int unsigned EntropyWidth = Shares * RandWidth;
  localparam int unsigned ShareIdxW    = (Shares > 1) ? $clog2(Shares) : 1;

  localparam logic [EntropyWidth-1:0] RndCnstSideloadSeedDefault = 64'h3b1c_5e7a_9d24_f681;

  // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
  localparam logic [EntropyWidth-1:0] SideloadLfsrTaps = 64'hd800_0000_0000_0000;

  typedef enum logic [2:0] {
    StReset,
    StInitSeed,
    StIdle,
    StClrSeed,
    StClr,
    StWipe,
    StDone
  } sideload_seq_state_e;

  typedef logic [Shares-1:0][RandWidth-1:0] sideload_entropy_t;

  function automatic logic [EntropyWidth-1:0] sideload_lfsr_step(
    input logic [EntropyWidth-1:0] s
  );
    sideload_lfsr_step = {1'b0, s[EntropyWidth-1:1]} ^ (s[0] ? SideloadLfsrTaps : '0);
  endfunction

endpackage

// File: rtl/keymgr_sideload_clr_seq_if.sv
// EDN request/acknowledge bundle between the sideload sequencer and the entropy source.
interface keymgr_sideload_clr_seq_if;
  import keymgr_pkg::*;

  logic                edn_req;
  logic                edn_ack;
  logic [EdnWidth-1:0] edn_data;

  modport master (output edn_req, input edn_ack, input edn_data);
  modport slave  (input edn_req, output edn_ack, output edn_data);

endinterface

// File: rtl/keymgr_sideload_prng.sv
// Reseedable Galois LFSR supplying masking entropy to the sideload key stage.
// A reseed word is folded into one share after any same-cycle advance.
module keymgr_sideload_prng
  import keymgr_pkg::*;
#(
  parameter logic [EntropyWidth-1:0] LfsrSeed = RndCnstSideloadSeedDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 reseed_en_i,
  input  logic [ShareIdxW-1:0] reseed_idx_i,
  input  logic [RandWidth-1:0] reseed_data_i,
  output sideload_entropy_t    entropy_o
);

  sideload_entropy_t lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = sideload_lfsr_step(lfsr_q);
    end
    if (reseed_en_i) begin
      lfsr_d[reseed_idx_i] = lfsr_d[reseed_idx_i] ^ reseed_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign entropy_o = lfsr_q;

endmodule

// File: rtl/keymgr_sideload_clr_seq.sv
// Sideload key clear/wipe sequencer: turns software clear pulses and fault wipe
// levels into fixed-length clr_key/wipe_key assertions and reseeds the masking PRNG.
module keymgr_sideload_clr_seq
  import keymgr_pkg::*;
#(
  parameter int unsigned             ClrCycles = 8,
  parameter logic [EntropyWidth-1:0] LfsrSeed  = RndCnstSideloadSeedDefault
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              init_i,
  input  logic                              sw_clr_req_i,
  input  logic                              fault_wipe_i,
  keymgr_sideload_clr_seq_if.master         edn,
  input  logic                              prng_en_i,
  output logic                              clr_key_o,
  output logic                              wipe_key_o,
  output sideload_entropy_t                 entropy_o,
  output logic                              busy_o,
  output logic                              clr_done_o,
  output logic                              wiped_o
);

  localparam int unsigned     HoldW    = $clog2(ClrCycles + 1);
  localparam int unsigned     AckW     = $clog2(Shares + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(ClrCycles - 1);
  localparam logic [AckW-1:0]  AckLast  = AckW'(Shares - 1);

  sideload_seq_state_e state_d, state_q;
  logic [AckW-1:0]     ack_cnt_d, ack_cnt_q;
  logic [HoldW-1:0]    hold_d, hold_q;
  logic                edn_req_d, edn_req_q;
  logic                clr_key_d, clr_key_q;
  logic                wipe_key_d, wipe_key_q;
  logic                clr_done_d, clr_done_q;
  logic                wiped_d, wiped_q;
  logic                fault_lat_d, fault_lat_q;
  logic                ack_seen;
  logic                reseed_en;

  assign ack_seen = edn_req_q & edn.edn_ack;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    ack_cnt_d   = ack_cnt_q;
    hold_d      = hold_q;
    edn_req_d   = edn_req_q & ~edn.edn_ack;
    clr_key_d   = 1'b0;
    wipe_key_d  = 1'b0;
    clr_done_d  = 1'b0;
    wiped_d     = wiped_q;
    fault_lat_d = fault_lat_q;
    reseed_en   = 1'b0;

    unique case (state_q)
      StReset: begin
        if (fault_wipe_i) begin
          fault_lat_d = 1'b1;
        end
        if (init_i) begin
          if (fault_lat_q || fault_wipe_i) begin
            state_d    = StWipe;
            hold_d     = '0;
            wipe_key_d = 1'b1;
          end else begin
            state_d   = StInitSeed;
            ack_cnt_d = '0;
            edn_req_d = 1'b1;
          end
        end
      end
      StInitSeed, StClrSeed: begin
        if (ack_seen) begin
          reseed_en = 1'b1;
          ack_cnt_d = ack_cnt_q + AckW'(1);
          if (ack_cnt_q == AckLast) begin
            if (state_q == StInitSeed) begin
              state_d = StIdle;
            end else begin
              state_d   = StClr;
              hold_d    = '0;
              clr_key_d = 1'b1;
            end
          end else begin
            edn_req_d = 1'b1;
          end
        end
      end
      StIdle: begin
        if (sw_clr_req_i) begin
          state_d   = StClrSeed;
          ack_cnt_d = '0;
          edn_req_d = 1'b1;
        end
      end
      StClr: begin
        if (hold_q == HoldLast) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end else begin
          hold_d    = hold_q + HoldW'(1);
          clr_key_d = 1'b1;
        end
      end
      StWipe: begin
        if (hold_q == HoldLast) begin
          state_d = StDone;
          wiped_d = 1'b1;
        end else begin
          hold_d     = hold_q + HoldW'(1);
          wipe_key_d = 1'b1;
        end
      end
      StDone: begin
        wiped_d = 1'b1;
      end
      default: begin
        state_d = StReset;
      end
    endcase

    // A live fault abandons any clear or reseed; an outstanding EDN request still completes
    if (fault_wipe_i && !(state_q inside {StReset, StWipe, StDone})) begin
      state_d    = StWipe;
      hold_d     = '0;
      wipe_key_d = 1'b1;
      clr_key_d  = 1'b0;
      clr_done_d = 1'b0;
      edn_req_d  = edn_req_q & ~edn.edn_ack;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StReset;
      ack_cnt_q   <= '0;
      hold_q      <= '0;
      edn_req_q   <= 1'b0;
      clr_key_q   <= 1'b0;
      wipe_key_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      wiped_q     <= 1'b0;
      fault_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_cnt_q   <= ack_cnt_d;
      hold_q      <= hold_d;
      edn_req_q   <= edn_req_d;
      clr_key_q   <= clr_key_d;
      wipe_key_q  <= wipe_key_d;
      clr_done_q  <= clr_done_d;
      wiped_q     <= wiped_d;
      fault_lat_q <= fault_lat_d;
    end
  end

  keymgr_sideload_prng #(
    .LfsrSeed (LfsrSeed)
  ) u_prng (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (prng_en_i),
    .reseed_en_i   (reseed_en),
    .reseed_idx_i  (ShareIdxW'(ack_cnt_q)),
    .reseed_data_i (edn.edn_data),
    .entropy_o     (entropy_o)
  );

  assign edn.edn_req = edn_req_q;
  assign clr_key_o   = clr_key_q;
  assign wipe_key_o  = wipe_key_q;
  assign clr_done_o  = clr_done_q;
  assign wiped_o     = wiped_q;
  assign busy_o      = (state_q != StIdle);

endmodule
